image_stream_feeder: RTL

- Synthesizable pixel source. Reads NUM_IMAGES raster-order frames from a synchronous pixel ROM and streams them one pixel per beat into conv1_layer.
- Replaces the free-running, testbench-only pixel loop.
- Adds a start/done control interface, valid/ready backpressure, line and frame markers, and multi-image sequencing.

---
 rtl/image_stream_feeder_if.sv | 24 ++
 rtl/image_stream_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_feeder_if.sv
// image_stream_feeder_if: the pixel stream between the feeder and the convolution layer.
// The stream carries a valid/ready handshake, line and frame markers, and the frame index.
interface image_stream_feeder_if #(
  parameter int PIX_BITS = 8,
  parameter int IDX_BITS = 1
);
  logic [PIX_BITS-1:0] data_out;
  logic                valid_out;
  logic                ready_in;
  logic                sol;
  logic                eol;
  logic                eof;
  logic [IDX_BITS-1:0] img_idx;

  modport master (
    output data_out, valid_out, sol, eol, eof, img_idx,
    input  ready_in
  );

  modport slave (
    input  data_out, valid_out, sol, eol, eof, img_idx,
    output ready_in
  );
endinterface

// File: rtl/image_stream_feeder.sv
// image_stream_feeder: reads NUM_IMAGES raster-order frames from a synchronous pixel ROM
// (one cycle read latency) and streams them one pixel per beat with valid/ready
// backpressure, sol/eol/eof markers, a frame index and start/busy/done control.
// Optional build macro FRAME_GAP_EN: inserts GAP_CYCLES idle cycles between frames.
module image_stream_feeder #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int PIX_BITS   = 8,
  parameter int NUM_IMAGES = 1,
  parameter int ADDR_BITS  = 10,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [PIX_BITS-1:0]  mem_data,
  image_stream_feeder_if.master strm,
  output logic                 busy,
  output logic                 done
);
  localparam int IDX_BITS = $clog2(NUM_IMAGES) + 1;
  localparam int COL_BITS = $clog2(IMG_WIDTH + 1);
  localparam int ROW_BITS = $clog2(IMG_HEIGHT + 1);
  localparam int TOTAL    = IMG_WIDTH * IMG_HEIGHT * NUM_IMAGES;

  localparam logic [ADDR_BITS:0]  LAST_COUNT = (ADDR_BITS + 1)'(TOTAL);
  localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(IMG_HEIGHT - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST   = IDX_BITS'(NUM_IMAGES - 1);

  // Reject configurations whose ROM address range cannot hold every frame.
  if ((64'd1 << ADDR_BITS) < 64'(TOTAL)) begin : g_bad_addr_bits
    $error("ADDR_BITS too small for IMG_WIDTH*IMG_HEIGHT*NUM_IMAGES");
  end

  // A negative gap length is meaningless in either build.
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("GAP_CYCLES must not be negative");
  end

`ifdef FRAME_GAP_EN
  localparam int GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  logic [GAP_BITS-1:0] r_gap_cnt;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd3
  } state_t;
`endif

  state_t              r_state;
  logic [ADDR_BITS:0]  r_addr;
  logic                r_pend;
  logic [PIX_BITS-1:0] r_buf0;
  logic [PIX_BITS-1:0] r_buf1;
  logic                r_v0;
  logic                r_v1;
  logic [COL_BITS-1:0] r_col;
  logic [ROW_BITS-1:0] r_row;
  logic [IDX_BITS-1:0] r_idx;
  logic                r_busy;
  logic                r_done;

  logic       w_valid;
  logic       w_pop;
  logic       w_last_col;
  logic       w_eof;
  logic [1:0] w_credit;
  logic       w_rd;

  // Entry 0 is only presented while running, so the gap (and idle) hides prefetched pixels.
  assign w_valid    = r_v0 & (r_state == S_RUN);
  assign w_pop      = w_valid & strm.ready_in;
  assign w_last_col = (r_col == COL_LAST);
  assign w_eof      = w_last_col & (r_row == ROW_LAST);

  // Outstanding entries after this cycle's accepted beat: buffered plus the one on the ROM bus.
  // Counting the beat accepted this cycle is what lets a 2-entry buffer sustain one pixel per
  // cycle; any read issued here lands when at most one entry can still be occupied.
  assign w_credit = 2'({1'b0, r_v0}) + 2'({1'b0, r_v1}) + 2'({1'b0, r_pend}) - 2'({1'b0, w_pop});
  assign w_rd     = (r_state == S_RUN) & (r_addr < LAST_COUNT) & (w_credit < 2'd2);

  assign mem_addr       = r_addr[ADDR_BITS-1:0];
  assign mem_rd_en      = w_rd;
  assign strm.data_out  = r_buf0;
  assign strm.valid_out = w_valid;
  assign strm.sol       = w_valid & (r_col == '0);
  assign strm.eol       = w_valid & w_last_col;
  assign strm.eof       = w_valid & w_eof;
  assign strm.img_idx   = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;

  // Sequential ROM address counter and tracking of the read whose data is on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_rd;
      if ((r_state == S_IDLE) && start) begin
        r_addr <= '0;
      end else if (w_rd) begin
        r_addr <= r_addr + (ADDR_BITS + 1)'(1);
      end else begin
        r_addr <= r_addr;
      end
    end
  end

  // Two-entry output buffer capturing ROM returns; entry 0 faces the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
    end else begin
      case ({w_pop, r_pend})
        2'b11: begin
          if (r_v1) begin
            r_buf0 <= r_buf1;
            r_buf1 <= mem_data;
          end else begin
            r_buf0 <= mem_data;
          end
        end
        2'b10: begin
          r_buf0 <= r_buf1;
          r_v0   <= r_v1;
          r_v1   <= 1'b0;
        end
        2'b01: begin
          if (!r_v0) begin
            r_buf0 <= mem_data;
            r_v0   <= 1'b1;
          end else begin
            r_buf1 <= mem_data;
            r_v1   <= 1'b1;
          end
        end
        default: begin
          r_buf0 <= r_buf0;
        end
      endcase
    end
  end

  // Run control FSM with output-side col/row/frame counters advancing on accepted beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef FRAME_GAP_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            if (w_eof) begin
              r_col <= '0;
              r_row <= '0;
              if (r_idx == IDX_LAST) begin
                r_state <= S_FIN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + IDX_BITS'(1);
`ifdef FRAME_GAP_EN
                if (GAP_CYCLES > 0) begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= GAP_LOAD;
                end
`endif
              end
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + ROW_BITS'(1);
            end else begin
              r_col <= r_col + COL_BITS'(1);
            end
          end
        end
`ifdef FRAME_GAP_EN
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_BITS'(1);
          end
        end
`endif
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
